// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: streams operands LSB-first through an external
// 1-bit full-subtractor cell and assembles the difference and final borrow.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             sub_a,
    output logic             sub_b,
    output logic             sub_carry,
    input  logic             sub_our,
    input  logic             sub_next
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic             borrow_reg;
    logic [CW-1:0]    cnt;
    logic             running;

    // The cell only ever sees live operand bits while RUN; otherwise it is parked at zero.
    assign running   = (state == RUN);
    assign sub_a     = running & a_sh[0];
    assign sub_b     = running & b_sh[0];
    assign sub_carry = running & borrow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            work       <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh       <= a_in;
                        b_sh       <= b_in;
                        work       <= '0;
                        borrow_reg <= 1'b0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    work       <= {sub_our, work[WIDTH-1:1]};
                    borrow_reg <= sub_next;
                    a_sh       <= a_sh >> 1;
                    b_sh       <= b_sh >> 1;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Final bit lands straight in the result together with the last borrow.
                        diff       <= {sub_our, work[WIDTH-1:1]};
                        borrow_out <= sub_next;
                        done       <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: behavioural cell, arithmetic reference model,
// directed corner cases plus randomized operand pairs.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         sub_a;
    logic         sub_b;
    logic         sub_carry;
    logic         sub_our;
    logic         sub_next;

    int checks   = 0;
    int failures = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_carry  (sub_carry),
        .sub_our    (sub_our),
        .sub_next   (sub_next)
    );

    // Behavioural 1-bit full subtractor standing in for the external cell.
    assign sub_our  = sub_a ^ sub_b ^ sub_carry;
    assign sub_next = (!sub_a && sub_b) || (!(sub_a ^ sub_b) && sub_carry);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Borrow entering bit i: the low i bits of a are smaller than the low i bits of b.
    function automatic logic borrow_into(input int a, input int b, input int i);
        int m;
        m = (1 << i) - 1;
        return ((a & m) < (b & m));
    endfunction

    // One operation from start to idle; poke fires extra start pulses in RUN cycle 3 and in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [W-1:0] exp_d;
        logic         exp_b;
        logic [W-1:0] prev_d;
        logic         prev_b;
        int dones, done_at, busy_n, unstable, port_err, idle_err;
        exp_d    = a - b;
        exp_b    = (int'(a) < int'(b));
        dones    = 0;
        done_at  = 0;
        busy_n   = 0;
        unstable = 0;
        port_err = 0;
        idle_err = 0;
        @(negedge clk);
        prev_d = diff;
        prev_b = borrow_out;
        rst    = 1'b0;
        a_in   = a;
        b_in   = b;
        start  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                dones++;
                done_at = n;
                chk("diff", diff, exp_d);
                chk("borrow_out", borrow_out, exp_b);
            end
            if (n <= W) begin
                if (diff !== prev_d || borrow_out !== prev_b) unstable++;
                if (sub_a !== a[n-1] || sub_b !== b[n-1] ||
                    sub_carry !== borrow_into(a, b, n - 1)) port_err++;
            end else if ({sub_a, sub_b, sub_carry} !== 3'b000) begin
                idle_err++;
            end
            start = poke && (n == 3 || n == W + 1);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            if (done_at != 0 && !busy) break;
        end
        chk("done_count", dones, 1);
        chk("done_latency", done_at, W + 1);
        chk("busy_cycles", busy_n, W + 1);
        chk("result_stable_in_run", unstable, 0);
        chk("cell_ports", port_err, 0);
        chk("cell_ports_idle", idle_err, 0);
        @(negedge clk);
        chk("no_extra_op", busy, 1'b0);
        chk("diff_hold", diff, exp_d);
    endtask

    initial begin
        int dones;
        int idles;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_diff", diff, 0);
        chk("reset_borrow", borrow_out, 1'b0);
        chk("reset_cell", {sub_a, sub_b, sub_carry}, 0);
        repeat (2) @(negedge clk);

        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b0);
        run_op(8'h10, 8'h01, 1'b1);
        run_op(8'h05, 8'h03, 1'b0);

        // Asynchronous reset in the middle of RUN cycle 4.
        @(negedge clk);
        a_in  = 8'h40;
        b_in  = 8'h07;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 1'b0);
        chk("abort_cell", {sub_a, sub_b, sub_carry}, 0);
        @(negedge clk);
        chk("abort_no_done", done, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);

        // start held high: a new operation every W+2 cycles.
        @(negedge clk);
        a_in  = 8'h37;
        b_in  = 8'h12;
        start = 1'b1;
        dones = 0;
        idles = 0;
        for (int k = 1; k <= 3 * (W + 2); k++) begin
            @(negedge clk);
            if (done) dones++;
            if (!busy) idles++;
        end
        start = 1'b0;
        chk("b2b_dones", dones, 3);
        chk("b2b_idle_cycles", idles, 3);
        chk("b2b_diff", diff, 8'h25);
        chk("b2b_borrow", borrow_out, 1'b0);
        repeat (W + 3) @(negedge clk);
        chk("b2b_quiet", busy, 1'b0);

        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);
        run_op(8'h80, 8'h7F, 1'b0);
        for (int r = 0; r < 300; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  minuend; captured on accepted start.
REQ-006 b_in  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 done  output  1  one-cycle pulse; diff/borrow_out valid from this cycle.
REQ-009 diff  output  WIDTH  result a - b mod 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; 1 when unsigned a < b.
REQ-011 sub_a  output  1  minuend bit to external 1-bit full-subtractor cell.
REQ-012 sub_b  output  1  subtrahend bit to cell.
REQ-013 sub_carry  output  1  borrow-in to cell.
REQ-014 sub_our  input  1  difference bit from cell (a^b^carry), combinational.
REQ-015 sub_next  input  1  borrow-out from cell, combinational.

Function
REQ-016 FSM states: IDLE, RUN, DONE; the block SHALL use the external cell for all arithmetic and SHALL NOT compute difference/borrow internally.
REQ-017 IDLE: start=1 at a clock edge SHALL load a_in/b_in into shift registers, clear borrow register and bit counter, and move to RUN; start=0 stays in IDLE.
REQ-018 RUN: cell inputs SHALL be combinational: sub_a = a_sh[0], sub_b = b_sh[0], sub_carry = borrow_reg.
REQ-019 RUN, each edge: sub_our shifted into work register at MSB side, borrow_reg <= sub_next, a_sh/b_sh shift right one, counter increments (LSB processed first).
REQ-020 RUN lasts exactly WIDTH cycles; on the edge ending the cycle with counter = WIDTH-1 the FSM SHALL go to DONE and load diff <= completed work register and borrow_out <= sub_next.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH; busy high from E0 through the DONE cycle inclusive.
REQ-023 start while busy (RUN or DONE) SHALL be ignored, no effect on operands, counter or result.
REQ-024 Back-to-back: start held high continuously SHALL start a new operation on the first edge in IDLE after DONE (one idle cycle minimum between operations).
REQ-025 Outside RUN, sub_a, sub_b, sub_carry SHALL be 0.
REQ-026 diff and borrow_out SHALL hold the last completed result until the next DONE load; they SHALL NOT change during RUN.
REQ-027 a_in/b_in changes after an accepted start SHALL not affect the running operation.

Reset
REQ-028 rst=1 SHALL immediately (without clock) force IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, borrow_reg=0, shift registers 0, sub_* outputs 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst deassertion SHALL behave as from power-up.
REQ-030 start sampled high on the first edge after rst deassertion SHALL be accepted.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, start pulse -> after 8 RUN cycles done=1, diff=0x02, borrow_out=0; busy high 9 cycles.
REQ-032 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-033 Exhaustive/random: all 65536 (a,b) pairs through a behavioral cell model -> diff=(a-b)&0xFF, borrow_out=(a<b) each time, exactly one done per start.
REQ-034 start=1 with a=0x10,b=0x01, then start pulses with different operands at RUN cycle 3 and in DONE cycle -> result 0x0F, borrow 0; no extra operation launched.
REQ-035 rst pulsed at RUN cycle 4 (asynchronously, mid-cycle) -> busy, done, diff, borrow_out drop to 0 immediately; no done pulse; next start with a=0xFF,b=0xFF -> diff=0x00, borrow_out=0.
REQ-036 Cell-port check during RUN for a=0xA5,b=0x5A: sub_a sequence 1,0,1,0,0,1,0,1; sub_b 0,1,0,1,1,0,1,0; sub_carry equals previous cycle's sub_next, 0 in first cycle.
